// File: rtl/lcd_mem_reader.sv
// Avalon-MM block reader: fetches word_count words into a small FIFO and unpacks them
// little-endian onto an 8-bit valid/ready stream. Define LCD_MEM_READER_ABORT_EN to add the abort input.
module lcd_mem_reader #(
  parameter int ADDR_W     = 16,
  parameter int MEM_WORDS  = 51200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
`ifdef LCD_MEM_READER_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [31:0]       mem_readdata,
  output logic [7:0]        st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] next_addr, last_addr;
  logic [15:0]       remaining, unpack_left;
  logic              inflight;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx;
  logic              cur_last;
  logic [7:0]        next_byte;
  logic              issue, push, pop, abort_act;

`ifdef LCD_MEM_READER_ABORT_EN
  assign abort_act = abort && ((state == FETCH) || (state == DRAIN));
`else
  assign abort_act = 1'b0;
`endif

  // Words already owned (buffered or in flight) must leave room for the next capture.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign issue = (state == FETCH) && (remaining != '0) &&
                 (credit_used < (CW+1)'(FIFO_DEPTH)) && !abort_act;
  assign push  = inflight && !abort_act;
  assign pop   = (fifo_count != '0) && !abort_act &&
                 (!st_valid || (st_ready && (byte_idx == 2'd3)));

  assign busy           = (state == FETCH) || (state == DRAIN);
  assign done           = (state == FIN);
  assign mem_chipselect = issue;
  assign mem_address    = issue ? next_addr : last_addr;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;

  always_comb begin
    case (byte_idx)
      2'd0:    next_byte = word_q[15:8];
      2'd1:    next_byte = word_q[23:16];
      default: next_byte = word_q[31:24];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (word_count == '0) ? FIN : FETCH;
      FETCH: if (abort_act) state_nxt = FIN;
             else if (issue && (remaining == 16'd1)) state_nxt = DRAIN;
      DRAIN: if (abort_act) state_nxt = FIN;
             else if ((fifo_count == '0) && !st_valid && !inflight) state_nxt = FIN;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      next_addr   <= '0;
      last_addr   <= '0;
      remaining   <= '0;
      unpack_left <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      word_q      <= '0;
      byte_idx    <= '0;
      cur_last    <= 1'b0;
      st_data     <= '0;
      st_valid    <= 1'b0;
      st_last     <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if ((state == IDLE) && start) begin
        next_addr   <= base_addr;
        remaining   <= word_count;
        unpack_left <= word_count;
      end
      if (issue) begin
        last_addr <= next_addr;
        next_addr <= (next_addr == ADDR_W'(MEM_WORDS - 1)) ? '0 : next_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        word_q      <= fifo_mem[rd_ptr];
        st_data     <= fifo_mem[rd_ptr][7:0];
        byte_idx    <= '0;
        st_valid    <= 1'b1;
        st_last     <= 1'b0;
        cur_last    <= (unpack_left == 16'd1);
        unpack_left <= unpack_left - 1'b1;
      end else if (st_valid && st_ready) begin
        if (byte_idx == 2'd3) begin
          st_valid <= 1'b0;
          st_last  <= 1'b0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          st_data  <= next_byte;
          st_last  <= cur_last && (byte_idx == 2'd2);
        end
      end
      // Abort flushes everything buffered; overrides the updates above.
      if (abort_act) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        st_valid   <= 1'b0;
        st_last    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lcd_mem_reader.sv
// Self-checking bench for lcd_mem_reader: memory model, stream monitor and a byte-queue reference.
module tb_lcd_mem_reader;
  localparam int ADDR_W     = 16;
  localparam int MEM_WORDS  = 51200;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset, start, abort, st_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       word_count;
  logic              busy, done, mem_chipselect, mem_write, st_valid, st_last;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;
  logic [7:0]        st_data;

  lcd_mem_reader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
`ifdef LCD_MEM_READER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_last(st_last)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem[int'(mem_address)];
    else                mem_readdata <= $urandom;
  end

  int n_vec, n_err;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [8:0] obs_bytes[$], exp_bytes[$];
  int obs_addr[$], exp_addr[$];
  int start_cyc, first_valid_cyc, last_hs_cyc, done_cyc, done_cnt;
  int issued, accepted, credit_viol, stall_viol, done_busy_viol, busy_seen;
  bit prev_stall;
  logic [7:0] prev_data;
  logic prev_last;
  logic [3:0] rst_snap;
  int addr_at_reset;
  logic abort_cs, abort_valid_after;

  always @(negedge clk) begin
    int loaded;
    cyc++;
    if (mon_en) begin
      if (start && start_cyc < 0) start_cyc = cyc;
      if (mem_chipselect) begin
        obs_addr.push_back(int'(mem_address));
        issued++;
      end
      loaded = st_valid ? (accepted / 4 + 1) : ((accepted + 3) / 4);
      if (issued - loaded > FIFO_DEPTH) credit_viol++;
      if (prev_stall && (!st_valid || st_data !== prev_data || st_last !== prev_last)) stall_viol++;
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      prev_last  = st_last;
      if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (st_valid && st_ready) begin
        obs_bytes.push_back({st_last, st_data});
        accepted++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) done_busy_viol++;
      end
      if (busy) busy_seen = 1;
    end
  end

  task automatic clear_mon();
    obs_bytes.delete(); obs_addr.delete();
    start_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0;
    issued = 0; accepted = 0; credit_viol = 0; stall_viol = 0; done_busy_viol = 0; busy_seen = 0;
    prev_stall = 1'b0; rst_snap = 'x; addr_at_reset = -1; abort_cs = 1'bx; abort_valid_after = 1'bx;
  endtask

  // Reference: word i of the block comes from (base+i) mod MEM_WORDS, bytes LSB first.
  function automatic void build_expect(input int base, input int count);
    exp_bytes.delete(); exp_addr.delete();
    for (int i = 0; i < count; i++) begin
      int a;
      logic [31:0] w;
      a = (base + i) % MEM_WORDS;
      exp_addr.push_back(a);
      w = mem[a];
      for (int b = 0; b < 4; b++)
        exp_bytes.push_back({(i == count - 1) && (b == 3), w[8*b +: 8]});
    end
  endfunction

  function automatic int byte_diff();
    int n = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) if (obs_bytes[i] !== exp_bytes[i]) return i;
    return (obs_bytes.size() == exp_bytes.size()) ? -1 : n;
  endfunction

  function automatic string byte_msg(input int d);
    logic [8:0] o, e;
    o = (d < obs_bytes.size()) ? obs_bytes[d] : 'x;
    e = (d < exp_bytes.size()) ? exp_bytes[d] : 'x;
    return $sformatf("byte %0d got last/data %0b/%02h required %0b/%02h (got %0d bytes, required %0d)",
                     d, o[8], o[7:0], e[8], e[7:0], obs_bytes.size(), exp_bytes.size());
  endfunction

  function automatic int addr_diff();
    int n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) if (obs_addr[i] != exp_addr[i]) return i;
    return (obs_addr.size() == exp_addr.size()) ? -1 : n;
  endfunction

  function automatic string addr_msg(input int d);
    int o, e;
    o = (d < obs_addr.size()) ? obs_addr[d] : -1;
    e = (d < exp_addr.size()) ? exp_addr[d] : -1;
    return $sformatf("read %0d got addr %0d required %0d (got %0d reads, required %0d)",
                     d, o, e, obs_addr.size(), exp_addr.size());
  endfunction

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      2:       return (k >= 20) && (k % 2 == 1);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic run_xfer(input int base, input int count, input int mode, input int abort_at,
                          input int mid_start, input int reset_at, input bit stop_on_done,
                          input int max_cyc);
    int tail = 0;
    bit aborted = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    mon_en = 1'b1;
    base_addr = ADDR_W'(base); word_count = 16'(count); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      st_ready = ready_for(mode, k);
      if (k == mid_start) begin
        start = 1'b1;
        base_addr = ADDR_W'($urandom_range(0, MEM_WORDS - 1));
        word_count = 16'd3;
      end
      if (k == reset_at) reset = 1'b1;
      if (abort_at >= 0 && !aborted && obs_bytes.size() == abort_at) begin
        aborted = 1'b1; st_ready = 1'b0; abort = 1'b1;
        #1 abort_cs = mem_chipselect;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (reset) begin
        reset = 1'b0;
        rst_snap = {st_valid, mem_chipselect, busy, done};
        addr_at_reset = obs_addr.size();
      end
      if (abort) begin
        abort = 1'b0;
        abort_valid_after = st_valid;
      end
      if (stop_on_done && done_cnt > 0) begin
        tail++;
        if (tail > 2) break;
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; word_count = 16'd4; base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, mem_chipselect, st_valid, st_last, st_data, mem_address, mem_write, mem_byteenable}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 4'hF}) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b cs=%b valid=%b last=%b data=%h addr=%h we=%b be=%h required all 0, be=f",
               busy, done, mem_chipselect, st_valid, st_last, st_data, mem_address, mem_write, mem_byteenable);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, mem_chipselect} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_beats_start: got busy/cs=%b%b required 00", busy, mem_chipselect);
    end
  endtask

  task automatic test_basic();
    int d;
    mem[16] = 32'h44332211; mem[17] = 32'h88776655;
    build_expect(16, 2);
    run_xfer(16, 2, 0, -1, -1, -1, 1'b1, 200);
    n_vec++; d = addr_diff();
    if (d != -1) begin n_err++; $display("FAIL basic_addr: %s", addr_msg(d)); end
    n_vec++; d = byte_diff();
    if (d != -1) begin n_err++; $display("FAIL basic_bytes: %s", byte_msg(d)); end
    n_vec++;
    if (done_cnt != 1 || done_busy_viol != 0) begin
      n_err++; $display("FAIL basic_done: got %0d pulses (%0d with busy) required 1 (0)", done_cnt, done_busy_viol);
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b required 0", busy); end
    n_vec++;
    if (first_valid_cyc < 0 || first_valid_cyc - start_cyc > 4) begin
      n_err++; $display("FAIL basic_latency: got %0d cycles required <= 4", first_valid_cyc - start_cyc);
    end
    n_vec++;
    if (last_hs_cyc - first_valid_cyc != 7) begin
      n_err++; $display("FAIL basic_rate: got %0d cycles for 8 bytes required 7", last_hs_cyc - first_valid_cyc);
    end
  endtask

  task automatic test_backpressure();
    int d, base;
    base = $urandom_range(0, MEM_WORDS - 9);
    for (int i = 0; i < 8; i++)
      mem[base + i] = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
    build_expect(base, 8);
    run_xfer(base, 8, 2, -1, -1, -1, 1'b1, 600);
    n_vec++; d = addr_diff();
    if (d != -1) begin n_err++; $display("FAIL bp_addr: %s", addr_msg(d)); end
    n_vec++; d = byte_diff();
    if (d != -1) begin n_err++; $display("FAIL bp_bytes: %s", byte_msg(d)); end
    n_vec++;
    if (credit_viol != 0) begin n_err++; $display("FAIL bp_credit: got %0d over-credit cycles required 0", credit_viol); end
    n_vec++;
    if (stall_viol != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stall cycles required 0", stall_viol); end
    n_vec++;
    if (done_cnt != 1) begin n_err++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_wrap();
    int d;
    build_expect(MEM_WORDS - 1, 2);
    run_xfer(MEM_WORDS - 1, 2, 3, -1, -1, -1, 1'b1, 400);
    n_vec++; d = addr_diff();
    if (d != -1) begin n_err++; $display("FAIL wrap_addr: %s", addr_msg(d)); end
    n_vec++; d = byte_diff();
    if (d != -1) begin n_err++; $display("FAIL wrap_bytes: %s", byte_msg(d)); end
  endtask

  task automatic test_zero();
    run_xfer($urandom_range(0, MEM_WORDS - 1), 0, 0, -1, -1, -1, 1'b1, 50);
    n_vec++;
    if (obs_addr.size() != 0 || obs_bytes.size() != 0) begin
      n_err++; $display("FAIL zero_traffic: got %0d reads %0d bytes required 0 0", obs_addr.size(), obs_bytes.size());
    end
    n_vec++;
    if (done_cnt != 1 || done_cyc - start_cyc != 1) begin
      n_err++; $display("FAIL zero_done: got %0d pulses at +%0d required 1 at +1", done_cnt, done_cyc - start_cyc);
    end
    n_vec++;
    if (busy_seen != 0) begin n_err++; $display("FAIL zero_busy: got busy=1 required never"); end
  endtask

  task automatic test_start_ignored();
    int d, base;
    base = $urandom_range(0, MEM_WORDS - 1);
    build_expect(base, 5);
    run_xfer(base, 5, 1, -1, 6, -1, 1'b1, 600);
    n_vec++; d = byte_diff();
    if (d != -1) begin n_err++; $display("FAIL midstart_bytes: %s", byte_msg(d)); end
    n_vec++; d = addr_diff();
    if (d != -1) begin n_err++; $display("FAIL midstart_addr: %s", addr_msg(d)); end
    n_vec++;
    if (done_cnt != 1) begin n_err++; $display("FAIL midstart_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    run_xfer($urandom_range(0, MEM_WORDS - 1), 6, 0, -1, -1, 8, 1'b0, 40);
    n_vec++;
    if (rst_snap !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_outputs: got valid/cs/busy/done=%b required 0000", rst_snap);
    end
    n_vec++;
    if (done_cnt != 0) begin n_err++; $display("FAIL rstmid_done: got %0d pulses required 0", done_cnt); end
    n_vec++;
    if (obs_addr.size() != addr_at_reset) begin
      n_err++; $display("FAIL rstmid_reads: got %0d reads after reset required 0", obs_addr.size() - addr_at_reset);
    end
  endtask

`ifdef LCD_MEM_READER_ABORT_EN
  task automatic test_abort();
    int d, base;
    base = $urandom_range(0, MEM_WORDS - 1);
    build_expect(base, 4);
    exp_bytes = exp_bytes[0:4];
    run_xfer(base, 4, 0, 5, -1, -1, 1'b1, 200);
    n_vec++; d = byte_diff();
    if (d != -1) begin n_err++; $display("FAIL abort_bytes: %s", byte_msg(d)); end
    n_vec++;
    if ({abort_cs, abort_valid_after} !== 2'b00) begin
      n_err++; $display("FAIL abort_stop: got cs/valid_after=%b%b required 00", abort_cs, abort_valid_after);
    end
    n_vec++;
    if (done_cnt != 1) begin n_err++; $display("FAIL abort_done: got %0d pulses required 1", done_cnt); end
    build_expect(base, 4);
    run_xfer(base, 4, 0, -1, -1, -1, 1'b1, 200);
    n_vec++; d = byte_diff();
    if (d != -1) begin n_err++; $display("FAIL abort_rerun: %s", byte_msg(d)); end
  endtask
`endif

  task automatic test_random();
    int d, base, count, mode;
    for (int it = 0; it < 8; it++) begin
      base  = ($urandom_range(0, 1) == 0) ? $urandom_range(MEM_WORDS - 6, MEM_WORDS - 1)
                                          : $urandom_range(0, MEM_WORDS - 1);
      count = $urandom_range(1, 10);
      mode  = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 1 : 3);
      build_expect(base, count);
      run_xfer(base, count, mode, -1, -1, -1, 1'b1, 800);
      n_vec++; d = byte_diff();
      if (d != -1) begin n_err++; $display("FAIL rand%0d_bytes: %s", it, byte_msg(d)); end
      n_vec++; d = addr_diff();
      if (d != -1) begin n_err++; $display("FAIL rand%0d_addr: %s", it, addr_msg(d)); end
      n_vec++;
      if (done_cnt != 1 || credit_viol != 0 || stall_viol != 0) begin
        n_err++;
        $display("FAIL rand%0d_ctrl: got done=%0d credit=%0d stall=%0d required 1 0 0",
                 it, done_cnt, credit_viol, stall_viol);
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; st_ready = 1'b0;
    base_addr = '0; word_count = '0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_start_ignored();
    test_reset_mid();
`ifdef LCD_MEM_READER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_mem_reader.md
Name: lcd_mem_reader

Overview:
- Avalon-MM read master directly downstream of the 32-bit on-chip program/data memory (51200 words, word address, read latency 1).
- Fetches a block of words, buffers them in a small word FIFO, and unpacks them little-endian into an 8-bit valid/ready byte stream for the LCD command/character writer.
- Software or the control FSM supplies the base address and word count, then pulses start.

Parameters:
- ADDR_W, 16, memory word-address width.
- MEM_WORDS, 51200, memory depth; the read address wraps from MEM_WORDS-1 to 0.
- FIFO_DEPTH, 4, word FIFO depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on an accepted start.
- word_count  in  16  number of words to read; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- mem_address  out  ADDR_W  word address to the memory.
- mem_chipselect  out  1  read strobe, one word per high cycle.
- mem_write  out  1  tied to 0.
- mem_byteenable  out  4  tied to 4'hF.
- mem_readdata  in  32  valid exactly 1 cycle after a mem_chipselect cycle.
- st_data  out  8  output byte.
- st_valid  out  1  st_data is valid.
- st_ready  in  1  downstream accepts the byte.
- st_last  out  1  marks the final byte of the block.

Behaviour:
- Reset:
  - All outputs 0 except mem_byteenable = 4'hF.
  - FSM goes to IDLE; FIFO, unpacker and counters are cleared; any in-flight read is discarded.
  - Reset wins over every other input in the same cycle.
- FSM states: IDLE, FETCH, DRAIN, FIN.
  - IDLE: start=1 latches base_addr/word_count. If word_count=0, go to FIN; otherwise go to FETCH.
  - FETCH: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty, the unpacker is empty, no read is in flight, and the last byte has been handshaked; then go to FIN.
  - FIN: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- busy is high in FETCH and DRAIN only. start while busy is ignored, with no effect on the current transfer.
- Read issue:
  - mem_chipselect=1 in a FETCH cycle iff remaining>0 and (fifo_count + inflight) < FIFO_DEPTH. inflight is 0 or 1.
  - Each issue advances the address by 1 (wrapping at MEM_WORDS) and decrements remaining.
  - mem_address holds its last value when chipselect=0.
- Capture: the cycle after an issue, mem_readdata is written into the FIFO unconditionally. The credit rule guarantees the FIFO is never full at that point.
- Unpacker:
  - Loads a word from the FIFO when it is empty, or when the current byte 3 is handshaked (back-to-back loads, no bubble).
  - Emits byte order [7:0], [15:8], [23:16], [31:24].
  - st_data, st_valid and st_last are registered and hold stable while st_valid=1 and st_ready=0.
  - st_last=1 only with byte 3 of word number word_count.
- Throughput: with st_ready tied to 1, the sustained rate is 1 byte/cycle. Reads throttle automatically because each word needs 4 cycles to drain.
- Latency: first st_valid no later than 3 cycles after the accepted start.
- Width rules: remaining is a 16-bit down-counter; the address uses ADDR_W bits with explicit wrap compare, not a power-of-2 wrap.
- FIFO simultaneous push and pop in one cycle: count is unchanged and the data order is preserved.

Optional Feature:
- Macro: LCD_MEM_READER_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit). abort=1 in FETCH or DRAIN stops issue immediately (chipselect=0 that cycle).
  - The in-flight word is dropped, and the FIFO and unpacker are flushed.
  - st_valid=0 from the next cycle; no st_last is emitted; the FSM goes to FIN (done pulse).
  - abort is ignored in IDLE and FIN.
- Without the macro: no abort port; transfers always run to completion or reset.

Test Plan:
- Base 0x0010, count 2, mem[0x10]=0x44332211, mem[0x11]=0x88776655, st_ready=1:
  - Expect exactly two chipselect cycles at addresses 0x0010 and 0x0011.
  - Expect bytes 11,22,33,44,55,66,77,88, with st_last only on 0x88.
  - Expect a done pulse once, then busy=0.
- Count 8 of incrementing words, st_ready held 0 for 20 cycles then toggled 1/0:
  - fifo_count + inflight never exceeds 4.
  - Exactly 32 bytes in order; st_data stable while stalled; 8 chipselect cycles total.
- Base 51199, count 2 -> addresses 51199 then 0; 8 bytes out in order.
- Count 0 -> no chipselect; done pulses 1 cycle after start; busy never rises.
- Start pulsed mid-transfer is ignored (same byte sequence). Reset asserted mid-transfer -> next cycle st_valid=0, chipselect=0, busy=0, and no done pulse.
- With LCD_MEM_READER_ABORT_EN, count 4, abort after 5 bytes -> st_valid=0 next cycle, no st_last, done pulse; a new start then reproduces the full 16-byte sequence.
